vga_map_capture: RTL
====================

VGA_MAP_CAPTURE -- requirements
Module: vga_map_capture

Interface
REQ-001 SHALL have parameter MAP_W, default 1406, map vector width in bits.
REQ-002 SHALL have parameter ACTIVE_RGB, default 24'h12AFAF, live-cell pixel colour.
REQ-003 SHALL have parameter CURSOR_RGB, default 24'hFF5C39, cursor-border pixel colour.
REQ-004 SHALL have one clock and a synchronous active-high reset: clk  input  1  pixel clock; reset  input  1  synchronous active-high reset.
REQ-005 SHALL have ports: vga_hs  input  1  hsync, low during pulse; vga_vs  input  1  vsync, low during pulse; vga_de  input  1  display enable.
REQ-006 SHALL have ports: vga_r / vga_g / vga_b  input  8 each  pixel colour.
REQ-007 SHALL have ports: largeur_grille  input  12  grid width in cells; hauteur_grille  input  12  grid height in cells; cell_w  input  12  cell width in pixels; cell_h  input  12  cell height in lines.
REQ-008 SHALL have ports: map_out  output  MAP_W  last captured map; map_valid  output  1  one-cycle publish pulse; frame_err  output  1  line-count mismatch on last frame.
REQ-009 SHALL have ports: cursor_found  output  1  cursor seen in last frame; h_position_du_curseur / v_position_du_curseur  output  12 each  cursor cell coordinates.

Function
REQ-010 SHALL run FSM states IDLE, CAPTURE, PUBLISH; IDLE->CAPTURE on vga_vs rising edge (end of sync); CAPTURE->PUBLISH on vga_vs falling edge; PUBLISH->CAPTURE after one cycle if vga_vs high, else IDLE.
REQ-011 SHALL stay in IDLE while any of largeur_grille, hauteur_grille, cell_w, cell_h is zero.
REQ-012 SHALL, on entry to CAPTURE, clear working map, pixel/line/cell counters, row base index, and working cursor flag.
REQ-013 SHALL count pixels only while vga_de high; x_in_cell wraps 0..cell_w-1, incrementing x_map on wrap; both reset on vga_de rising edge; first de-high pixel is x_in_cell=0, x_map=0.
REQ-014 SHALL, on vga_de falling edge, advance y_in_cell 0..cell_h-1, increment y_map and add largeur_grille to row base on wrap, and increment active line count.
REQ-015 SHALL sample when x_in_cell==cell_w>>1 and y_in_cell==cell_h>>1 with x_map<largeur_grille and y_map<hauteur_grille: working bit[row_base+x_map] <= ({r,g,b}==ACTIVE_RGB); no multiplier or divider used.
REQ-016 SHALL ignore samples whose index >= MAP_W (no write, no wrap).
REQ-017 SHALL, when x_in_cell==0, y_in_cell==cell_h>>1, in-grid, and {r,g,b}==CURSOR_RGB, latch x_map/y_map as working cursor and set working flag; first hit per frame wins.
REQ-018 SHALL in PUBLISH copy working map to map_out, working cursor to cursor outputs, assert map_valid for exactly that cycle, set frame_err = (line count != hauteur_grille*cell_h, computed once per frame by shift-add or registered at frame start).
REQ-019 SHALL hold map_out, cursor outputs and frame_err stable between publishes.
REQ-020 SHALL treat vga_vs falling edge in the same cycle as vga_de falling edge as line end first, then publish next cycle.
REQ-021 SHALL ignore vga_hs except for edge-detector registers (reserved); timing derives from vga_de and vga_vs only.

Reset
REQ-022 SHALL on reset: state IDLE, map_out all zero, map_valid 0, frame_err 0, cursor_found 0, cursor coordinates 0, working buffer and counters zero, edge-detect registers loaded as 1 for vga_vs and 0 for vga_de.
REQ-023 SHALL, on reset mid-frame, discard the partial frame with no publish; capture restarts at the next vga_vs rising edge.

Structure
REQ-024 SHALL place MAP_W default, ACTIVE_RGB, CURSOR_RGB, border colour 24'h32D8E0, and FSM state encoding in shared package vga_pkg.
REQ-025 SHALL implement the wrap counter (in-cell counter + cell index, clear, enable, wrap pulse) as sub-module vga_cell_counter, instantiated for x and y.

Verification
REQ-026 Grid 4x3, cell 8x8, 32x24 active, all cells ACTIVE_RGB centre pixels -> map_valid once after vs falls, map_out[11:0]=12'hFFF, frame_err=0.
REQ-027 Same grid, only cell (2,1) active -> map_out[6]=1, all other bits 0.
REQ-028 Cursor colour at left border of cell (3,2) -> cursor_found=1, h=3, v=2; next frame without cursor -> cursor_found=0.
REQ-029 Frame with 20 active lines instead of 24 -> frame_err=1, map_valid still pulses.
REQ-030 Reset asserted mid-frame at line 10 -> no map_valid, map_out=0; following full frame publishes correctly.
REQ-031 largeur_grille=40, hauteur_grille=40 (1600 cells > MAP_W) -> indices >=1406 unwritten, no X on map_out, bits 0..1405 correct.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants and FSM encoding for the VGA map-capture block.
package vga_pkg;

    localparam int          MAP_W_DEFAULT      = 1406;
    localparam logic [23:0] ACTIVE_RGB_DEFAULT = 24'h12AFAF;
    localparam logic [23:0] CURSOR_RGB_DEFAULT = 24'hFF5C39;
    localparam logic [23:0] BORDER_RGB         = 24'h32D8E0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_PUBLISH = 2'd2
    } state_t;

endpackage

// File: rtl/vga_cell_counter.sv
// Position-within-cell counter plus cell index; wrap pulses combinationally on the last position.
module vga_cell_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        en,
    input  logic [11:0] limit,
    output logic [11:0] in_cell,
    output logic [11:0] index,
    output logic        wrap
);

    assign wrap = en && (in_cell == limit - 12'd1);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            in_cell <= '0;
            index   <= '0;
        end else if (en) begin
            if (wrap) begin
                in_cell <= '0;
                index   <= index + 12'd1;
            end else begin
                in_cell <= in_cell + 12'd1;
            end
        end
    end

endmodule

// File: rtl/vga_map_capture.sv
// Samples the centre pixel of every grid cell of a VGA frame into a bit map and locates a
// cursor marker; the map and cursor are published once per frame on the vsync falling edge.
module vga_map_capture
    import vga_pkg::*;
#(
    parameter int          MAP_W      = MAP_W_DEFAULT,
    parameter logic [23:0] ACTIVE_RGB = ACTIVE_RGB_DEFAULT,
    parameter logic [23:0] CURSOR_RGB = CURSOR_RGB_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             vga_hs,
    input  logic             vga_vs,
    input  logic             vga_de,
    input  logic [7:0]       vga_r,
    input  logic [7:0]       vga_g,
    input  logic [7:0]       vga_b,
    input  logic [11:0]      largeur_grille,
    input  logic [11:0]      hauteur_grille,
    input  logic [11:0]      cell_w,
    input  logic [11:0]      cell_h,
    output logic [MAP_W-1:0] map_out,
    output logic             map_valid,
    output logic             frame_err,
    output logic             cursor_found,
    output logic [11:0]      h_position_du_curseur,
    output logic [11:0]      v_position_du_curseur
);

    localparam int          IDX_W     = (MAP_W > 1) ? $clog2(MAP_W) : 1;
    localparam logic [23:0] MAP_LIMIT = 24'(MAP_W);

    state_t           state;
    logic             vs_q, de_q, hs_unused;
    logic [MAP_W-1:0] work_map;
    logic [23:0]      row_base, line_cnt;
    logic [23:0]      mul_acc, mul_cand;
    logic [11:0]      mul_plier;
    logic             cur_flag;
    logic [11:0]      cur_h, cur_v;
    logic [11:0]      x_in, x_map, y_in, y_map;
    logic             x_wrap_unused, y_wrap;

    logic             vs_rise, vs_fall, de_fall;
    logic             params_ok, capturing, start;
    logic             in_grid, centre_hit, cursor_hit;
    logic [23:0]      pix, idx;
    logic [IDX_W-1:0] widx;

    assign vs_rise    = vga_vs & ~vs_q;
    assign vs_fall    = ~vga_vs & vs_q;
    assign de_fall    = ~vga_de & de_q;
    assign params_ok  = (largeur_grille != 12'd0) && (hauteur_grille != 12'd0) &&
                        (cell_w != 12'd0) && (cell_h != 12'd0);
    assign capturing  = (state == ST_CAPTURE);
    assign start      = ((state == ST_IDLE) && params_ok && vs_rise) ||
                        ((state == ST_PUBLISH) && vga_vs);

    assign pix        = {vga_r, vga_g, vga_b};
    assign idx        = row_base + {12'd0, x_map};
    assign widx       = idx[IDX_W-1:0];
    assign in_grid    = (x_map < largeur_grille) && (y_map < hauteur_grille);
    assign centre_hit = capturing && vga_de && in_grid &&
                        (x_in == (cell_w >> 1)) && (y_in == (cell_h >> 1));
    assign cursor_hit = capturing && vga_de && in_grid && !cur_flag &&
                        (x_in == 12'd0) && (y_in == (cell_h >> 1)) && (pix == CURSOR_RGB);

    // Horizontal counters are held at zero during blanking so the first visible pixel is cell 0.
    vga_cell_counter u_x_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear   (start | ~vga_de),
        .en      (capturing & vga_de),
        .limit   (cell_w),
        .in_cell (x_in),
        .index   (x_map),
        .wrap    (x_wrap_unused)
    );

    vga_cell_counter u_y_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear   (start),
        .en      (capturing & de_fall),
        .limit   (cell_h),
        .in_cell (y_in),
        .index   (y_map),
        .wrap    (y_wrap)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state                 <= ST_IDLE;
            vs_q                  <= 1'b1;
            de_q                  <= 1'b0;
            hs_unused             <= 1'b1;
            work_map              <= '0;
            row_base              <= '0;
            line_cnt              <= '0;
            mul_acc               <= '0;
            mul_cand              <= '0;
            mul_plier             <= '0;
            cur_flag              <= 1'b0;
            cur_h                 <= '0;
            cur_v                 <= '0;
            map_out               <= '0;
            map_valid             <= 1'b0;
            frame_err             <= 1'b0;
            cursor_found          <= 1'b0;
            h_position_du_curseur <= '0;
            v_position_du_curseur <= '0;
        end else begin
            vs_q      <= vga_vs;
            de_q      <= vga_de;
            hs_unused <= vga_hs;
            map_valid <= 1'b0;

            if (start) begin
                work_map  <= '0;
                row_base  <= '0;
                line_cnt  <= '0;
                cur_flag  <= 1'b0;
                mul_acc   <= '0;
                mul_cand  <= {12'd0, cell_h};
                mul_plier <= hauteur_grille;
            end else begin
                // Expected line count = hauteur_grille * cell_h, one shift-add step per cycle.
                if (mul_plier != 12'd0) begin
                    if (mul_plier[0])
                        mul_acc <= mul_acc + mul_cand;
                    mul_cand  <= mul_cand << 1;
                    mul_plier <= mul_plier >> 1;
                end
                if (capturing && de_fall)
                    line_cnt <= line_cnt + 24'd1;
                if (y_wrap)
                    row_base <= row_base + {12'd0, largeur_grille};
                if (centre_hit && (idx < MAP_LIMIT))
                    work_map[widx] <= (pix == ACTIVE_RGB);
                if (cursor_hit) begin
                    cur_flag <= 1'b1;
                    cur_h    <= x_map;
                    cur_v    <= y_map;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (start)
                        state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (vs_fall)
                        state <= ST_PUBLISH;
                end
                ST_PUBLISH: begin
                    map_out               <= work_map;
                    map_valid             <= 1'b1;
                    frame_err             <= (line_cnt != mul_acc);
                    cursor_found          <= cur_flag;
                    h_position_du_curseur <= cur_h;
                    v_position_du_curseur <= cur_v;
                    state                 <= vga_vs ? ST_CAPTURE : ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
